// File: rtl/command_decoder_pkg.sv
// Shared definitions for the host command decoder: field positions, opcodes,
// error codes, readback tags, FSM state encoding and readback-word builders.
package command_decoder_pkg;

  localparam int CMD_W = 32;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_DAC_WR = 4'h1;
  localparam logic [3:0] OP_ADC_WR = 4'h2;
  localparam logic [3:0] OP_ADC_RD = 4'h3;
  localparam logic [3:0] OP_ECHO   = 4'h4;

  localparam logic [3:0] ERR_ILLEGAL = 4'h1;
  localparam logic [3:0] ERR_TIMEOUT = 4'h2;

  localparam logic [3:0] TAG_ADC_RD = 4'h3;
  localparam logic [3:0] TAG_ERR    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WSTART = 3'd4,
    S_WDONE  = 3'd5,
    S_RB     = 3'd6
  } state_e;

  function automatic logic [CMD_W-1:0] err_word(input logic [3:0] code,
                                                input logic [CMD_W-1:0] cmd);
    return {TAG_ERR, code, cmd[23:0]};
  endfunction

  function automatic logic [CMD_W-1:0] adc_rb_word(input logic [CMD_W-1:0] cmd,
                                                   input logic [7:0] data);
    return {TAG_ADC_RD, cmd[27:16], 8'h00, data};
  endfunction

endpackage

// File: rtl/command_decoder_spi_txn_timer.sv
// Bounded wait timer for one SPI transaction: counts enabled cycles after a
// clear and flags expiry once TIMEOUT_CYCLES have elapsed.
module spi_txn_timer #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/command_decoder.sv
// Drains host command words, issues single SPI requests toward spi_controller
// and writes echo / ADC readback / error words into the readback FIFO.
module command_decoder
  import command_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [31:0] cmd_q,
  input  logic        cmd_empty,
  output logic        cmd_rdreq,
  output logic [31:0] rb_data,
  output logic        rb_wrreq,
  input  logic        rb_full,
  output logic        dac_request_write,
  output logic [3:0]  dac_address,
  output logic [15:0] dac_value,
  output logic        adc_request_write,
  output logic        adc_request_read,
  output logic [10:0] adc_address,
  output logic [7:0]  adc_value,
  input  logic [7:0]  adc_value_readback,
  input  logic        busy,
  output logic        data_ready,
  output logic        idle,
  output logic [15:0] cmd_count,
  output logic [7:0]  err_count
);

  state_e      r_state, w_next;
  logic        r_armed;
  logic [31:0] r_cmd, r_rb_word, w_rb_word;
  logic        r_rb_is_err, w_rb_err, w_rb_load;
  logic [3:0]  w_op;
  logic        w_expired, w_issue, w_rb_fire;

  logic        r_dac_req, r_adc_wr, r_adc_rd, r_rb_wrreq, r_idle;
  logic [3:0]  r_dac_addr;
  logic [15:0] r_dac_val, r_cmd_count;
  logic [10:0] r_adc_addr;
  logic [7:0]  r_adc_val, r_err_count;
  logic [31:0] r_rb_data;

  assign w_op = r_cmd[31:28];

  // Held off for the first cycle after reset release so no read strobe can
  // coincide with the FSM coming out of reset.
  assign cmd_rdreq = r_armed && (r_state == S_IDLE) && !cmd_empty;

  spi_txn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .i_clear  (r_state == S_ISSUE),
    .i_enable ((r_state == S_WSTART) || (r_state == S_WDONE)),
    .o_expired(w_expired)
  );

  // NOTE: every combinational output is defaulted before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_rb_load = 1'b0;
    w_rb_word = r_cmd;
    w_rb_err  = 1'b0;
    case (r_state)
      S_IDLE:   if (cmd_rdreq) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_NOP:  w_next = S_IDLE;
          OP_ECHO: begin
            w_next    = S_RB;
            w_rb_load = 1'b1;
          end
          OP_DAC_WR, OP_ADC_WR, OP_ADC_RD: if (!busy) w_next = S_ISSUE;
          default: begin
            w_next    = S_RB;
            w_rb_load = 1'b1;
            w_rb_word = err_word(ERR_ILLEGAL, r_cmd);
            w_rb_err  = 1'b1;
          end
        endcase
      end
      S_ISSUE:  w_next = S_WSTART;
      S_WSTART: begin
        if (busy) begin
          w_next = S_WDONE;
        end else if (w_expired) begin
          w_next    = S_RB;
          w_rb_load = 1'b1;
          w_rb_word = err_word(ERR_TIMEOUT, r_cmd);
          w_rb_err  = 1'b1;
        end
      end
      S_WDONE: begin
        if (!busy) begin
          if (w_op == OP_ADC_RD) begin
            w_next    = S_RB;
            w_rb_load = 1'b1;
            w_rb_word = adc_rb_word(r_cmd, adc_value_readback);
          end else begin
            w_next = S_IDLE;
          end
        end else if (w_expired) begin
          w_next    = S_RB;
          w_rb_load = 1'b1;
          w_rb_word = err_word(ERR_TIMEOUT, r_cmd);
          w_rb_err  = 1'b1;
        end
      end
      S_RB:     if (!rb_full) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_issue   = (r_state == S_DECODE) && (w_next == S_ISSUE);
  assign w_rb_fire = (r_state == S_RB) && !rb_full;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_armed     <= 1'b0;
      r_cmd       <= '0;
      r_rb_word   <= '0;
      r_rb_is_err <= 1'b0;
      r_dac_req   <= 1'b0;
      r_adc_wr    <= 1'b0;
      r_adc_rd    <= 1'b0;
      r_rb_wrreq  <= 1'b0;
      r_idle      <= 1'b1;
      r_dac_addr  <= '0;
      r_dac_val   <= '0;
      r_adc_addr  <= '0;
      r_adc_val   <= '0;
      r_cmd_count <= '0;
      r_err_count <= '0;
      r_rb_data   <= '0;
    end else begin
      r_state    <= w_next;
      r_armed    <= 1'b1;
      r_idle     <= (w_next == S_IDLE);
      r_dac_req  <= w_issue && (w_op == OP_DAC_WR);
      r_adc_wr   <= w_issue && (w_op == OP_ADC_WR);
      r_adc_rd   <= w_issue && (w_op == OP_ADC_RD);
      r_rb_wrreq <= w_rb_fire;
      if (r_state == S_FETCH) begin
        r_cmd       <= cmd_q;
        r_cmd_count <= r_cmd_count + 1'b1;
      end
      if (w_rb_load) begin
        r_rb_word   <= w_rb_word;
        r_rb_is_err <= w_rb_err;
      end
      // Request fields load with the pulse and hold until the next issue.
      if (w_issue) begin
        r_dac_addr <= r_cmd[19:16];
        r_dac_val  <= r_cmd[15:0];
        r_adc_addr <= r_cmd[26:16];
        r_adc_val  <= r_cmd[7:0];
      end
      if (w_rb_fire) begin
        r_rb_data <= r_rb_word;
        if (r_rb_is_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign rb_data           = r_rb_data;
  assign rb_wrreq          = r_rb_wrreq;
  assign data_ready        = r_rb_wrreq;
  assign dac_request_write = r_dac_req;
  assign dac_address       = r_dac_addr;
  assign dac_value         = r_dac_val;
  assign adc_request_write = r_adc_wr;
  assign adc_request_read  = r_adc_rd;
  assign adc_address       = r_adc_addr;
  assign adc_value         = r_adc_val;
  assign idle              = r_idle;
  assign cmd_count         = r_cmd_count;
  assign err_count         = r_err_count;

endmodule

// File: tb/tb_command_decoder.sv
// Directed bench for command_decoder: FIFO and spi_controller behavioural
// models around the DUT, one task per scenario with inline checks.
module tb_command_decoder;

  localparam int TIMEOUT = 4096;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic [31:0] cmd_q;
  logic        cmd_empty;
  logic        cmd_rdreq;
  logic [31:0] rb_data;
  logic        rb_wrreq;
  logic        rb_full;
  logic        dac_request_write;
  logic [3:0]  dac_address;
  logic [15:0] dac_value;
  logic        adc_request_write;
  logic        adc_request_read;
  logic [10:0] adc_address;
  logic [7:0]  adc_value;
  logic [7:0]  adc_value_readback;
  logic        busy;
  logic        data_ready;
  logic        idle;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;

  command_decoder #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(13)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .cmd_q(cmd_q), .cmd_empty(cmd_empty), .cmd_rdreq(cmd_rdreq),
    .rb_data(rb_data), .rb_wrreq(rb_wrreq), .rb_full(rb_full),
    .dac_request_write(dac_request_write), .dac_address(dac_address), .dac_value(dac_value),
    .adc_request_write(adc_request_write), .adc_request_read(adc_request_read),
    .adc_address(adc_address), .adc_value(adc_value),
    .adc_value_readback(adc_value_readback), .busy(busy),
    .data_ready(data_ready), .idle(idle), .cmd_count(cmd_count), .err_count(err_count)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo[$];
  bit          pop_pending = 0;
  bit          spi_start   = 0;
  int          busy_len    = 0;
  int          busy_cnt    = 0;
  int          cyc         = 0;

  int n_dac, n_adc_wr, n_adc_rd, n_rb, n_dr, n_ovr, n_bad_rdreq;
  int rdreq_cyc, req_cyc, rb_cyc;
  logic [19:0] last_dac;
  logic [18:0] last_adc;
  logic [31:0] last_rb;

  // Observation of the DUT away from the active edge.
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      if (cmd_rdreq) n_bad_rdreq++;
    end else begin
      if (cmd_rdreq) begin rdreq_cyc = cyc; pop_pending = 1'b1; end
      if (dac_request_write) begin n_dac++; req_cyc = cyc; last_dac = {dac_address, dac_value}; spi_start = 1'b1; end
      if (adc_request_write) begin n_adc_wr++; req_cyc = cyc; last_adc = {adc_address, adc_value}; spi_start = 1'b1; end
      if (adc_request_read) begin n_adc_rd++; req_cyc = cyc; last_adc = {adc_address, adc_value}; spi_start = 1'b1; end
      if (rb_wrreq) begin n_rb++; rb_cyc = cyc; last_rb = rb_data; if (rb_full) n_ovr++; end
      if (data_ready) n_dr++;
    end
  end

  // Non-showahead command FIFO and a spi_controller that stays busy for busy_len cycles.
  always @(posedge sys_clk) begin
    cyc++;
    #1;
    if (pop_pending) begin
      pop_pending = 1'b0;
      if (fifo.size() > 0) cmd_q = fifo.pop_front();
      cmd_empty = (fifo.size() == 0);
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) busy = 1'b0;
      spi_start = 1'b0;
    end else if (spi_start) begin
      spi_start = 1'b0;
      if (busy_len > 0) begin busy = 1'b1; busy_cnt = busy_len; end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    cmd_empty = 1'b0;
  endtask

  task automatic clear_counts();
    n_dac = 0; n_adc_wr = 0; n_adc_rd = 0; n_rb = 0; n_dr = 0; n_ovr = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sys_clk);
      if (idle && cmd_empty && !pop_pending && !busy) begin ok = 1'b1; break; end
    end
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_empty = 1'b1; cmd_q = '0; busy = 1'b0; rb_full = 1'b0;
    adc_value_readback = 8'h00; n_bad_rdreq = 0; clear_counts();
    repeat (2) @(negedge sys_clk);
    total++; if ({cmd_rdreq, rb_wrreq, dac_request_write, adc_request_write, adc_request_read, data_ready, idle} !== 7'b0000001) begin bad++; $display("FAIL reset_strobes got=%b want=0000001", {cmd_rdreq, rb_wrreq, dac_request_write, adc_request_write, adc_request_read, data_ready, idle}); end
    total++; if ({rb_data, dac_address, dac_value, adc_address, adc_value, cmd_count, err_count} !== '0) begin bad++; $display("FAIL reset_buses got rb=%h dac=%h/%h adc=%h/%h cnt=%h err=%h want all 0", rb_data, dac_address, dac_value, adc_address, adc_value, cmd_count, err_count); end
    @(posedge sys_clk); #1 reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    total++; if (idle !== 1'b1 || cmd_rdreq !== 1'b0) begin bad++; $display("FAIL reset_release got idle=%b rdreq=%b want 1/0", idle, cmd_rdreq); end
  endtask

  task automatic test_dac_write();
    bit ok;
    clear_counts(); busy_len = 10;
    @(posedge sys_clk); #1 push(32'h1003_1234);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL dac_wait got=timeout want=idle"); end
    total++; if (n_dac !== 1) begin bad++; $display("FAIL dac_pulses got=%0d want=1", n_dac); end
    total++; if (last_dac !== 20'h3_1234) begin bad++; $display("FAIL dac_fields got=%h want=31234", last_dac); end
    total++; if (req_cyc - rdreq_cyc !== 3) begin bad++; $display("FAIL dac_latency got=%0d want=3", req_cyc - rdreq_cyc); end
    total++; if (n_rb !== 0 || n_adc_wr + n_adc_rd !== 0) begin bad++; $display("FAIL dac_side_effects got rb=%0d adc=%0d want 0/0", n_rb, n_adc_wr + n_adc_rd); end
    total++; if ({dac_address, dac_value} !== 20'h3_1234) begin bad++; $display("FAIL dac_hold got=%h want=31234", {dac_address, dac_value}); end
    total++; if (cmd_count !== 16'd1) begin bad++; $display("FAIL dac_cmd_count got=%0d want=1", cmd_count); end
  endtask

  task automatic test_adc();
    bit ok;
    clear_counts(); busy_len = 4; adc_value_readback = 8'hA5;
    @(posedge sys_clk); #1 push(32'h3205_0000);
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL adc_rd_wait got=timeout want=idle"); end
    total++; if (n_adc_rd !== 1 || n_adc_wr !== 0 || n_dac !== 0) begin bad++; $display("FAIL adc_rd_pulses got rd=%0d wr=%0d dac=%0d want 1/0/0", n_adc_rd, n_adc_wr, n_dac); end
    total++; if (last_adc[18:8] !== 11'h205) begin bad++; $display("FAIL adc_rd_addr got=%h want=205", last_adc[18:8]); end
    total++; if (n_rb !== 1 || last_rb !== 32'h3205_00A5) begin bad++; $display("FAIL adc_rd_word got n=%0d data=%h want 1/320500a5", n_rb, last_rb); end
    total++; if (n_dr !== 1) begin bad++; $display("FAIL adc_rd_ready got=%0d want=1", n_dr); end
    clear_counts();
    @(posedge sys_clk); #1 push(32'h2112_00C3);
    wait_idle(200, ok);
    total++; if (!ok || n_adc_wr !== 1 || last_adc !== {11'h112, 8'hC3}) begin bad++; $display("FAIL adc_wr got ok=%b n=%0d fields=%h want 1/1/%h", ok, n_adc_wr, last_adc, {11'h112, 8'hC3}); end
    total++; if (n_rb !== 0) begin bad++; $display("FAIL adc_wr_rb got=%0d want=0", n_rb); end
  endtask

  task automatic test_rb_full();
    bit ok;
    clear_counts(); rb_full = 1'b1;
    @(posedge sys_clk); #1 push(32'h4ABC_DEF0);
    repeat (20) @(negedge sys_clk);
    total++; if (n_rb !== 0 || idle !== 1'b0) begin bad++; $display("FAIL echo_hold got writes=%0d idle=%b want 0/0", n_rb, idle); end
    @(posedge sys_clk); #1 rb_full = 1'b0;
    wait_idle(50, ok);
    total++; if (!ok || n_rb !== 1 || last_rb !== 32'h4ABC_DEF0) begin bad++; $display("FAIL echo_word got ok=%b n=%0d data=%h want 1/1/4abcdef0", ok, n_rb, last_rb); end
    total++; if (n_dr !== 1 || n_ovr !== 0) begin bad++; $display("FAIL echo_ready got ready=%0d overrun=%0d want 1/0", n_dr, n_ovr); end
  endtask

  task automatic test_errors();
    bit ok;
    clear_counts();
    @(posedge sys_clk); #1 push(32'h7012_3456);
    wait_idle(50, ok);
    total++; if (!ok || last_rb !== 32'hF112_3456) begin bad++; $display("FAIL illegal_word got ok=%b data=%h want 1/f1123456", ok, last_rb); end
    total++; if (err_count !== 8'd1) begin bad++; $display("FAIL illegal_err_count got=%0d want=1", err_count); end
    clear_counts(); busy_len = 0;
    @(posedge sys_clk); #1 push(32'h2000_0000);
    wait_idle(TIMEOUT + 200, ok);
    total++; if (!ok || n_rb !== 1 || last_rb !== 32'hF200_0000) begin bad++; $display("FAIL timeout_word got ok=%b n=%0d data=%h want 1/1/f2000000", ok, n_rb, last_rb); end
    total++; if (rb_cyc - req_cyc < TIMEOUT || rb_cyc - req_cyc > TIMEOUT + 8) begin bad++; $display("FAIL timeout_delay got=%0d want %0d..%0d", rb_cyc - req_cyc, TIMEOUT, TIMEOUT + 8); end
    total++; if (err_count !== 8'd2) begin bad++; $display("FAIL timeout_err_count got=%0d want=2", err_count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(posedge sys_clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge sys_clk); #1 reset_n = 1'b1;
    clear_counts();
    @(posedge sys_clk); #1;
    for (int i = 0; i < 300; i++) push(32'h0000_0000 | i);
    wait_idle(2000, ok);
    total++; if (!ok || cmd_count !== 16'd300) begin bad++; $display("FAIL nop_count got ok=%b count=%0d want 1/300", ok, cmd_count); end
    total++; if (err_count !== 8'd0 || n_rb !== 0) begin bad++; $display("FAIL nop_side_effects got err=%0d rb=%0d want 0/0", err_count, n_rb); end
    @(posedge sys_clk); #1;
    for (int i = 0; i < 300; i++) push(32'h8000_0000 | i);
    wait_idle(4000, ok);
    total++; if (!ok || err_count !== 8'hFF) begin bad++; $display("FAIL err_saturate got ok=%b err=%0d want 1/255", ok, err_count); end
    total++; if (cmd_count !== 16'd600 || n_rb !== 300 || n_dr !== 300) begin bad++; $display("FAIL illegal_stream got cnt=%0d rb=%0d ready=%0d want 600/300/300", cmd_count, n_rb, n_dr); end
    total++; if (last_rb !== 32'hF100_012B) begin bad++; $display("FAIL illegal_last got=%h want=f100012b", last_rb); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_counts(); busy_len = 40; n_bad_rdreq = 0;
    @(posedge sys_clk); #1 push(32'h1005_0077);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin @(negedge sys_clk); if (busy) begin ok = 1'b1; break; end end
    total++; if (!ok) begin bad++; $display("FAIL mid_busy got=timeout want=busy"); end
    repeat (3) @(posedge sys_clk);
    #1 reset_n = 1'b0; push(32'h1009_BEEF);
    @(negedge sys_clk);
    total++; if (idle !== 1'b1 || cmd_count !== 16'd0 || {dac_address, dac_value} !== 20'h0 || cmd_rdreq !== 1'b0) begin bad++; $display("FAIL mid_reset_state got idle=%b cnt=%0d dac=%h rdreq=%b want 1/0/0/0", idle, cmd_count, {dac_address, dac_value}, cmd_rdreq); end
    @(posedge sys_clk); #1 reset_n = 1'b1; clear_counts();
    @(negedge sys_clk);
    total++; if (cmd_rdreq !== 1'b0 || n_bad_rdreq !== 0) begin bad++; $display("FAIL mid_release_rdreq got rdreq=%b in_reset=%0d want 0/0", cmd_rdreq, n_bad_rdreq); end
    wait_idle(300, ok);
    total++; if (!ok || n_dac !== 1 || last_dac !== 20'h9_BEEF) begin bad++; $display("FAIL mid_next_cmd got ok=%b n=%0d fields=%h want 1/1/9beef", ok, n_dac, last_dac); end
    total++; if (cmd_count !== 16'd1 || n_rb !== 0) begin bad++; $display("FAIL mid_next_count got cnt=%0d rb=%0d want 1/0", cmd_count, n_rb); end
  endtask

  initial begin
    test_reset();
    test_dac_write();
    test_adc();
    test_rb_full();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
